ex_mem_stage: RTL and testbench

Execute-to-memory pipeline register that sits directly downstream of the ALU. It captures the ALU result and branch decision together with the instruction's control fields, resolves control flow (conditional branch, JAL, JALR), and issues a one-cycle PC redirect to fetch. It then squashes the wrong-path instructions still in flight upstream, and presents a valid/ready beat to the memory stage.

---
 rtl/ex_mem_stage_if.sv | 44 ++++
 rtl/ex_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bus: upstream beat, downstream beat and fetch redirect.
// The stage connects through the slave modport; its environment uses master.
interface ex_mem_stage_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] alu_result_i;
  logic        branch_i;
  logic        jal_i;
  logic        jalr_i;
  logic [4:0]  rd_i;
  logic        reg_write_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] store_data_i;
  logic        flush_i;

  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] store_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        misalign_o;

  modport slave (
    input  valid_i, pc_i, imm_i, alu_result_i, branch_i, jal_i, jalr_i, rd_i,
           reg_write_i, mem_read_i, mem_write_i, store_data_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, rd_o, reg_write_o, mem_read_o, mem_write_o,
           store_data_o, redirect_o, redirect_pc_o, misalign_o
  );

  modport master (
    output valid_i, pc_i, imm_i, alu_result_i, branch_i, jal_i, jalr_i, rd_i,
           reg_write_i, mem_read_i, mem_write_i, store_data_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, rd_o, reg_write_o, mem_read_o, mem_write_o,
           store_data_o, redirect_o, redirect_pc_o, misalign_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches/jumps, pulses a fetch redirect and squashes wrong-path beats.
// Optional MISALIGN_TRAP_EN: a misaligned taken target is forwarded as a trap beat instead of redirecting.
module ex_mem_stage #(
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  ex_mem_stage_if.slave bus
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;
  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_DEPTH);

  logic [0:0]  state_q;
  logic [2:0]  cnt_q;
  logic        valid_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] store_data_q;

  logic        ready;
  logic        accept;
  logic        taken;
  logic        is_jump;
  logic [31:0] target;
  logic [31:0] result_next;
  logic [31:0] redirect_pc_next;
  logic        do_redirect;
  logic        kill_ctrl;

  assign ready       = !valid_q || bus.ready_i;
  assign accept      = bus.valid_i && ready;
  assign taken       = bus.branch_i | bus.jal_i | bus.jalr_i;
  assign is_jump     = bus.jal_i | bus.jalr_i;
  assign target      = bus.jalr_i ? {bus.alu_result_i[31:1], 1'b0} : (bus.pc_i + bus.imm_i);
  assign result_next = is_jump ? (bus.pc_i + 32'd4) : bus.alu_result_i;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_q;

  assign misaligned       = taken && (target[1:0] != 2'b00);
  assign redirect_pc_next = target;
  assign do_redirect      = taken && !misaligned;
  assign kill_ctrl        = misaligned;

  // Trap flag travels with the beat it was computed for; squashed beats never load it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (!bus.flush_i && state_q == RUN && accept) begin
      misalign_q <= misaligned;
    end
  end

  assign bus.misalign_o = valid_q & misalign_q;
`else
  assign redirect_pc_next = target & ~32'h3;
  assign do_redirect      = taken;
  assign kill_ctrl        = 1'b0;
  assign bus.misalign_o   = 1'b0;
`endif

  // Flush outranks everything but reset; in SQUASH, accepted beats only count down.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      valid_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      result_q      <= 32'd0;
      rd_q          <= 5'd0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      store_data_q  <= 32'd0;
    end else if (bus.flush_i) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept) begin
            valid_q      <= 1'b1;
            result_q     <= result_next;
            rd_q         <= bus.rd_i;
            reg_write_q  <= bus.reg_write_i & ~kill_ctrl;
            mem_read_q   <= bus.mem_read_i & ~kill_ctrl;
            mem_write_q  <= bus.mem_write_i & ~kill_ctrl;
            store_data_q <= bus.store_data_i;
            if (do_redirect) begin
              redirect_q    <= 1'b1;
              redirect_pc_q <= redirect_pc_next;
              state_q       <= SQUASH;
              cnt_q         <= SQUASH_LOAD;
            end
          end else if (bus.ready_i) begin
            valid_q <= 1'b0;
          end
        end
        SQUASH: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
          end
          if (accept) begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid_q;
  assign bus.result_o      = result_q;
  assign bus.rd_o          = rd_q;
  assign bus.reg_write_o   = reg_write_q;
  assign bus.mem_read_o    = mem_read_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.store_data_o  = store_data_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver predicts beats/redirects into queues,
// a negedge monitor pops and compares them against what the stage presents.
module tb_ex_mem_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        mis;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redir_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic        ready;
    logic        flush;
  } stim_t;

  beat_t  exp_q[$];
  redir_t redir_q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;
  bit     exp_valid = 1'b0;
  bit     exp_ready = 1'b1;
  bit     held = 1'b0;
  int     squash_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model for one accepted, unsquashed instruction.
  task automatic modelBeat(input stim_t s);
    beat_t       b;
    redir_t      r;
    logic [31:0] tgt;
    bit          tk;
    bit          mis;
    tk  = s.br || s.jal || s.jalr;
    tgt = s.jalr ? (s.alu - (s.alu % 2)) : (s.pc + s.imm);
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = tk && (tgt % 4 != 0);
`endif
    b.result = (s.jal || s.jalr) ? s.pc + 32'd4 : s.alu;
    b.rd     = s.rd;
    b.rw     = s.rw && !mis;
    b.mr     = s.mr && !mis;
    b.mw     = s.mw && !mis;
    b.sd     = s.sd;
    b.mis    = mis;
    exp_q.push_back(b);
    if (tk && !mis) begin
      r.cyc = cyc + 1;
`ifdef MISALIGN_TRAP_EN
      r.pc = tgt;
`else
      r.pc = tgt - (tgt % 4);
`endif
      redir_q.push_back(r);
      squash_left = DEPTH;
    end
  endtask

  // Called at posedge+1: drives one cycle of inputs and advances the model across the next edge.
  task automatic applyStimulus(input stim_t s);
    bus.valid_i      = s.valid;
    bus.pc_i         = s.pc;
    bus.imm_i        = s.imm;
    bus.alu_result_i = s.alu;
    bus.branch_i     = s.br;
    bus.jal_i        = s.jal;
    bus.jalr_i       = s.jalr;
    bus.rd_i         = s.rd;
    bus.reg_write_i  = s.rw;
    bus.mem_read_i   = s.mr;
    bus.mem_write_i  = s.mw;
    bus.store_data_i = s.sd;
    bus.ready_i      = s.ready;
    bus.flush_i      = s.flush;
    exp_valid = held;
    exp_ready = !held || s.ready;
    if (s.flush) begin
      if (held && !s.ready && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      held = 1'b0;
      squash_left = 0;
    end else begin
      if (held && s.ready) held = 1'b0;
      if (s.valid && exp_ready) begin
        if (squash_left > 0) begin
          squash_left--;
        end else begin
          modelBeat(s);
          held = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t aluBeat(input logic [31:0] alu);
    stim_t s;
    s.valid = 1'b1; s.pc = 32'h0000_1000; s.imm = 32'd0; s.alu = alu;
    s.br = 1'b0; s.jal = 1'b0; s.jalr = 1'b0; s.rd = 5'd3;
    s.rw = 1'b1; s.mr = 1'b0; s.mw = 1'b0; s.sd = alu ^ 32'hA5A5_0000;
    s.ready = 1'b1; s.flush = 1'b0;
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = aluBeat(32'd0);
    s.valid = 1'b0;
    return s;
  endfunction

  function automatic stim_t randBeat();
    stim_t s;
    int    kind;
    s = aluBeat($urandom);
    s.valid = ($urandom_range(0, 9) < 8);
    s.pc    = $urandom & 32'hFFFF_FFFC;
    s.imm   = {{19{1'b0}}, 13'($urandom)};
    if (s.imm[12]) s.imm = s.imm | 32'hFFFF_E000;
    if ($urandom_range(0, 3) != 0) s.imm = s.imm & 32'hFFFF_FFFC;
    s.rd    = 5'($urandom);
    s.rw    = 1'($urandom);
    s.mr    = 1'($urandom);
    s.mw    = 1'($urandom);
    s.sd    = $urandom;
    kind    = $urandom_range(0, 5);
    s.br    = (kind == 1);
    s.jal   = (kind == 2);
    s.jalr  = (kind == 3);
    s.ready = ($urandom_range(0, 3) != 0);
    s.flush = ($urandom_range(0, 31) == 0);
    return s;
  endfunction

  // Monitor: handshake, beat payload and redirect pulse checks, decoupled from the driver.
  always @(negedge clk) begin
    beat_t  got;
    beat_t  e;
    redir_t r;
    if (mon_en) begin
      checkOutput("ready_o", 80'(bus.ready_o), 80'(exp_ready));
      checkOutput("valid_o", 80'(bus.valid_o), 80'(exp_valid));
      if (bus.valid_o && bus.ready_i) begin
        got = '{bus.result_o, bus.rd_o, bus.reg_write_o, bus.mem_read_o,
                bus.mem_write_o, bus.store_data_o, bus.misalign_o};
        if (exp_q.size() == 0) begin
          checkOutput("unexpected beat", 80'(got), 80'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat", 80'(got), 80'(e));
        end
      end
      if (redir_q.size() > 0 && redir_q[0].cyc <= cyc) begin
        r = redir_q.pop_front();
        checkOutput("redirect_o", 80'(bus.redirect_o), 80'(1));
        if (bus.redirect_o) checkOutput("redirect_pc_o", 80'(bus.redirect_pc_o), 80'(r.pc));
      end else begin
        checkOutput("redirect_o idle", 80'(bus.redirect_o), 80'(0));
      end
    end
  end

  task automatic checkResetState();
    checkOutput("reset valid_o", 80'(bus.valid_o), 80'(0));
    checkOutput("reset ready_o", 80'(bus.ready_o), 80'(1));
    checkOutput("reset redirect_o", 80'(bus.redirect_o), 80'(0));
    checkOutput("reset misalign_o", 80'(bus.misalign_o), 80'(0));
    checkOutput("reset redirect_pc_o", 80'(bus.redirect_pc_o), 80'(0));
    checkOutput("reset result_o", 80'(bus.result_o), 80'(0));
    checkOutput("reset store_data_o", 80'(bus.store_data_o), 80'(0));
    checkOutput("reset ctrl", 80'({bus.rd_o, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o}), 80'(0));
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    bus.valid_i = 1'b1; bus.pc_i = 32'h100; bus.imm_i = 32'h20; bus.alu_result_i = 32'h55;
    bus.branch_i = 1'b1; bus.jal_i = 1'b0; bus.jalr_i = 1'b0; bus.rd_i = 5'd7;
    bus.reg_write_i = 1'b1; bus.mem_read_i = 1'b1; bus.mem_write_i = 1'b1;
    bus.store_data_i = 32'hDEAD_BEEF; bus.ready_i = 1'b1; bus.flush_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    @(negedge clk);
    checkResetState();
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.branch_i = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    applyStimulus(aluBeat(32'h5));
    applyStimulus(aluBeat(32'hA));
    applyStimulus(aluBeat(32'hF));
    applyStimulus(idle());

    s = aluBeat(32'h0); s.pc = 32'h100; s.imm = 32'h20; s.br = 1'b1;
    applyStimulus(s);
    applyStimulus(aluBeat(32'h111));
    applyStimulus(aluBeat(32'h222));
    applyStimulus(aluBeat(32'h333));
    applyStimulus(idle());

    s = aluBeat(32'h2003); s.pc = 32'h40; s.rd = 5'd1; s.jalr = 1'b1;
    applyStimulus(s);
    applyStimulus(aluBeat(32'h444));
    applyStimulus(aluBeat(32'h555));
    applyStimulus(aluBeat(32'h666));

    applyStimulus(aluBeat(32'h11));
    for (int i = 0; i < 3; i++) begin
      s = aluBeat(32'h22); s.ready = 1'b0;
      applyStimulus(s);
    end
    applyStimulus(aluBeat(32'h22));
    applyStimulus(aluBeat(32'h33));
    applyStimulus(aluBeat(32'h44));

    s = aluBeat(32'h0); s.pc = 32'h200; s.imm = 32'h40; s.br = 1'b1;
    applyStimulus(s);
    s = aluBeat(32'h77); s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(aluBeat(32'h88));
    applyStimulus(aluBeat(32'h99));

    s = aluBeat(32'h0); s.pc = 32'h300; s.jal = 1'b1; s.imm = 32'h80; s.ready = 1'b0;
    applyStimulus(s);
    s = aluBeat(32'hAB); s.ready = 1'b0;
    applyStimulus(s);
    applyStimulus(aluBeat(32'hAB));
    applyStimulus(aluBeat(32'hCD));
    applyStimulus(aluBeat(32'hEF));

    for (int i = 0; i < 600; i++) applyStimulus(randBeat());

    for (int i = 0; i < 8; i++) applyStimulus(idle());
    mon_en = 1'b0;
    checkOutput("leftover beats", 80'(exp_q.size()), 80'(0));
    checkOutput("leftover redirects", 80'(redir_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
